// File: rtl/stage4_msg_dispatch.sv
// rtl/stage4_msg_dispatch.sv - byte-serial message assembler and three-lane group dispatcher
// Messages are assembled MSB-first, classified by type byte, and issued in groups of up to three.
module stage4_msg_dispatch #(
   parameter int              MSG_BYTES    = 32,
   parameter int              CTRL_W       = 3,
   parameter logic [CTRL_W-1:0] MUX_NONE   = 3'd0,
   parameter logic [CTRL_W-1:0] MUX_A      = 3'd1,
   parameter logic [CTRL_W-1:0] MUX_D      = 3'd2,
   parameter logic [CTRL_W-1:0] MUX_K      = 3'd3,
   parameter logic [CTRL_W-1:0] MUX_Q      = 3'd4,
   parameter int              FLUSH_CYCLES = 64,
   localparam int             MSG_BITS     = 8 * MSG_BYTES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                in_sop,
   input  logic                in_eop,
   input  logic [7:0]          in_data,
   input  logic                flush,
   output logic                message_en,
   output logic [MSG_BITS-1:0] message_1,
   output logic [MSG_BITS-1:0] message_2,
   output logic [MSG_BITS-1:0] message_3,
   output logic [CTRL_W-1:0]   message_mux_control_m1,
   output logic [CTRL_W-1:0]   message_mux_control_m2,
   output logic [CTRL_W-1:0]   message_mux_control_m3,
   output logic [15:0]         group_count,
   output logic                err_type,
   output logic                err_len
);

   localparam int IDX_W = $clog2(MSG_BYTES) + 1;
   localparam int TMR_W = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BODY    = 2'd1,
      S_DISCARD = 2'd2
   } asm_state_t;

   asm_state_t          state;
   logic [MSG_BITS-1:0] asm_buf;
   logic [IDX_W-1:0]    idx;
   logic [CTRL_W-1:0]   cur_code;
   logic                disc_type;

   logic [MSG_BITS-1:0] slot_data [3];
   logic [CTRL_W-1:0]   slot_code [3];
   logic [1:0]          slot_cnt;
   logic [TMR_W-1:0]    timer;
   logic                grp_ready;

   logic                type_known;
   logic [CTRL_W-1:0]   type_code;
   logic                body_room;
   logic [IDX_W+1:0]    shamt;
   logic [MSG_BITS-1:0] ins_word;
   logic                commit;
   logic [MSG_BITS-1:0] commit_word;
   logic [CTRL_W-1:0]   commit_code;

   always_comb begin
      type_known = 1'b1;
      type_code  = MUX_NONE;
      case (in_data)
         8'h41:   type_code = MUX_A;
         8'h44:   type_code = MUX_D;
         8'h4B:   type_code = MUX_K;
         8'h51:   type_code = MUX_Q;
         default: type_known = 1'b0;
      endcase
      body_room   = (idx < IDX_W'(MSG_BYTES));
      shamt       = {idx[IDX_W-2:0], 3'b000};
      ins_word    = {in_data, {(MSG_BITS-8){1'b0}}} >> shamt;
      // A completing beat is either a known single-beat message or the eop of a message still in range.
      commit      = in_valid && in_eop &&
                    (in_sop ? type_known : ((state == S_BODY) && body_room));
      commit_word = in_sop ? {in_data, {(MSG_BITS-8){1'b0}}} : (asm_buf | ins_word);
      commit_code = in_sop ? type_code : cur_code;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         asm_buf   <= '0;
         idx       <= '0;
         cur_code  <= MUX_NONE;
         disc_type <= 1'b0;
         err_type  <= 1'b0;
         err_len   <= 1'b0;
      end else begin
         err_type <= 1'b0;
         err_len  <= 1'b0;
         if (in_valid) begin
            if (in_sop) begin
               // A new type byte always wins; whatever was in flight is dropped with an error.
               if (state == S_BODY) begin
                  err_len <= 1'b1;
               end else if (state == S_DISCARD) begin
                  if (disc_type) err_type <= 1'b1;
                  else           err_len  <= 1'b1;
               end
               if (type_known) begin
                  asm_buf  <= {in_data, {(MSG_BITS-8){1'b0}}};
                  idx      <= IDX_W'(1);
                  cur_code <= type_code;
                  state    <= in_eop ? S_IDLE : S_BODY;
               end else begin
                  disc_type <= 1'b1;
                  if (in_eop) begin
                     err_type <= 1'b1;
                     state    <= S_IDLE;
                  end else begin
                     state    <= S_DISCARD;
                  end
               end
            end else begin
               case (state)
                  S_BODY: begin
                     if (body_room) begin
                        asm_buf <= asm_buf | ins_word;
                        idx     <= idx + IDX_W'(1);
                        if (in_eop) state <= S_IDLE;
                     end else if (in_eop) begin
                        err_len <= 1'b1;
                        state   <= S_IDLE;
                     end else begin
                        disc_type <= 1'b0;
                        state     <= S_DISCARD;
                     end
                  end
                  S_DISCARD: begin
                     if (in_eop) begin
                        if (disc_type) err_type <= 1'b1;
                        else           err_len  <= 1'b1;
                        state <= S_IDLE;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            slot_data[k] <= '0;
            slot_code[k] <= MUX_NONE;
         end
         slot_cnt               <= 2'd0;
         timer                  <= '0;
         grp_ready              <= 1'b0;
         message_en             <= 1'b0;
         message_1              <= '0;
         message_2              <= '0;
         message_3              <= '0;
         message_mux_control_m1 <= MUX_NONE;
         message_mux_control_m2 <= MUX_NONE;
         message_mux_control_m3 <= MUX_NONE;
         group_count            <= 16'd0;
      end else begin
         message_en <= 1'b0;
         if (grp_ready) begin
            // Unused slots were cleared at the previous issue, so they already read as NONE/zero.
            message_1              <= slot_data[0];
            message_2              <= slot_data[1];
            message_3              <= slot_data[2];
            message_mux_control_m1 <= slot_code[0];
            message_mux_control_m2 <= slot_code[1];
            message_mux_control_m3 <= slot_code[2];
            message_en             <= 1'b1;
            group_count            <= group_count + 16'd1;
            timer                  <= '0;
            slot_data[1]           <= '0;
            slot_code[1]           <= MUX_NONE;
            slot_data[2]           <= '0;
            slot_code[2]           <= MUX_NONE;
            if (commit) begin
               slot_data[0] <= commit_word;
               slot_code[0] <= commit_code;
               slot_cnt     <= 2'd1;
               grp_ready    <= flush;
            end else begin
               slot_data[0] <= '0;
               slot_code[0] <= MUX_NONE;
               slot_cnt     <= 2'd0;
               grp_ready    <= 1'b0;
            end
         end else if (commit) begin
            for (int k = 0; k < 3; k++) begin
               if (slot_cnt == 2'(k)) begin
                  slot_data[k] <= commit_word;
                  slot_code[k] <= commit_code;
               end
            end
            slot_cnt <= slot_cnt + 2'd1;
            timer    <= '0;
            if (slot_cnt == 2'd2 || flush) grp_ready <= 1'b1;
         end else if (slot_cnt != 2'd0) begin
            timer <= timer + TMR_W'(1);
            if (flush || timer == TMR_W'(FLUSH_CYCLES - 1)) grp_ready <= 1'b1;
         end
      end
   end

endmodule

// File: doc/stage4_msg_dispatch.md
# stage4_msg_dispatch

Upstream neighbour of the stage-5 field extractors. Assembles a byte-serial market-data message stream into fixed-width message words, classifies each message by its leading type byte, and packs up to three messages into one group presented on lanes 1–3. Each group is presented with a per-lane mux-control code and a one-cycle `message_en` strobe. All stage-5 extractors consume these outputs directly and combinationally.

## Interface
- `MSG_BYTES`, 32: message word length in bytes; `MSG_BITS = 8*MSG_BYTES` equals `MAX_MESSAGE_BITS`.
- `CTRL_W`, 3: width of mux-control codes.
- `MUX_NONE`/`MUX_A`/`MUX_D`/`MUX_K`/`MUX_Q`, 0/1/2/3/4: control codes, equal to the `message_mux_*` values.
- `FLUSH_CYCLES`, 64: idle cycles after which a partial group is issued.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  byte beat valid.
- `in_sop`  in  1  first byte of message (type byte); qualified by `in_valid`.
- `in_eop`  in  1  last byte of message; qualified by `in_valid`.
- `in_data`  in  8  byte.
- `flush`  in  1  force issue of the current partial group.
- `message_en`  out  1  one-cycle strobe: new group on lanes.
- `message_1`/`message_2`/`message_3`  out  MSG_BITS each  lane message words.
- `message_mux_control_m1`/`_m2`/`_m3`  out  CTRL_W each  lane type code.
- `group_count`  out  16  number of groups issued; wraps 0xFFFF→0.
- `err_type`  out  1  one-cycle pulse: message dropped, unknown type.
- `err_len`  out  1  one-cycle pulse: message dropped, overlong or aborted.

## Operation
- **Assembler states:** IDLE, BODY, DISCARD.
- **IDLE:** beats without `in_sop` are ignored. A `sop` beat:
  - decodes the type byte: 0x41→A, 0x44→D, 0x4B→K, 0x51→Q;
  - clears the buffer, stores the byte at bits [MSG_BITS-1 -: 8], and sets byte index 1;
  - goes to BODY, or completes immediately if `in_eop` is also set.
- **Unknown type byte:** go to DISCARD (or stay in IDLE if `sop`&`eop`) and pulse `err_type` on the eop beat.
- **BODY:** byte *i* is written to bits [MSG_BITS-1-8*i -: 8]. Unwritten bytes read as 0 (MSB-first, zero-filled).
- **Overlong message:** a beat with index ≥ MSG_BYTES moves to DISCARD; `err_len` pulses at that message's eop.
- **`in_sop` during BODY:** the current message is dropped with an `err_len` pulse on that beat, and the new message starts on the same beat.
- **DISCARD:** bytes are ignored until eop, then IDLE. A `sop` in DISCARD restarts assembly as in IDLE.
- **Commit:** a completed valid message is written to the group slot at `slot_cnt` (0..2) together with its code, and `slot_cnt` increments.
- **Group ready:** `slot_cnt` reaching 3 marks the group ready.
- **Flush timer:**
  - counts cycles while `slot_cnt` is 1–2 and no commit occurs; any commit clears it;
  - at FLUSH_CYCLES, or on `flush` with `slot_cnt` ≥ 1, the group is ready.
  - `flush` with an empty group does nothing.
- **Issue (edge after ready):**
  - lane registers load slot data and codes; unused lanes get code `MUX_NONE` and data 0;
  - `message_en`=1 for one cycle; `group_count`++;
  - the group slots and `slot_cnt` clear.
- **Hold:** lane outputs hold between strobes; downstream samples them while `message_en`=1.
- **Ordering:** lane order equals arrival order (lane 1 = oldest).

## Timing
- **Reset:** `rst` asserted clears, immediately:
  - all outputs: `message_en`=0, lanes 0, codes `MUX_NONE`, `group_count`=0, err pulses 0;
  - the assembler to IDLE, `slot_cnt`=0, and the timer.
- **Reset mid-message:** the message is lost without an error pulse.
- **Commit:** eop beat accepted at edge E → slot written at E.
- **Full-group latency:** a third commit at E → lanes loaded and `message_en` high during cycle E+1..E+2 (2 edges eop→strobe).
- **Timeout:** the timer hits FLUSH_CYCLES at edge T → issue at T+1.
- **`flush`:** sampled at edge F → issue at F+1.
- **Commit in issue cycle:** a commit on the same edge as an issue lands in slot 0 of the new (cleared) group; no message is lost.
- **Throughput:** minimum message is a single sop+eop beat, so one commit per cycle is sustained. `in_ready` is absent; the block never back-pressures.
- **Error pulses:** one cycle, coincident with the edge that drops the message.

## Test plan
- Three back-to-back messages 'A'+31 bytes, 'D'+5 bytes, 'Q' alone → one `message_en` 2 edges after the third eop:
  - codes 1/2/4;
  - `message_2` = 0x44,b1..b5 followed by zeros;
  - `group_count`=1.
- One 'K' message, then idle → after 64 idle cycles, issue with m1=3, m2=m3=0, lanes 2–3 zero; with `flush` pulsed 3 cycles after eop, issue on the edge after `flush`.
- Type byte 0x5A then eop → `err_type` pulse, no commit, `slot_cnt` unchanged; 40-byte 'A' message → `err_len` at eop, dropped.
- `sop` mid-message → `err_len` pulse, new message assembled correctly, only it is issued.
- Continuous single-beat messages for 9 cycles → exactly 3 strobes, no message lost across issue edges, `group_count`=3; then `rst` mid-stream → all outputs zero, codes 0 asynchronously.
